id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL provide parameter WB_BYPASS, default 1, meaning same-cycle write-back to read forwarding enabled (0 = read returns old register value).
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000000, meaning instruction word loaded into the IF/ID register at reset.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 i_ID_data_instruction  in  32  fetched instruction from IF.
REQ-006 i_ID_data_PCNext  in  32  PC+4 of fetched instruction, from IF.
REQ-007 i_ID_ctrl_Stall  in  1  hold IF/ID register, inject bubble to EX; IF is held by the same signal externally.
REQ-008 i_ID_ctrl_WbEn / i_ID_data_WbAddr / i_ID_data_WbData  in  1/5/32  register-file write port from WB.
REQ-009 o_IF_ctrl_PCSrc / o_IF_data_PCBranch  out  1/32  redirect request and target to IF.
REQ-010 o_EX_data_RsData / o_EX_data_RtData / o_EX_data_Imm  out  32 each  operands, sign-extended immediate.
REQ-011 o_EX_data_Rs / o_EX_data_Rt / o_EX_data_Rd  out  5 each  register specifiers.
REQ-012 o_EX_ctrl_Valid, o_EX_ctrl_RegWrite, o_EX_ctrl_MemRead, o_EX_ctrl_MemWrite, o_EX_ctrl_ALUSrc, o_EX_ctrl_RegDst  out  1 each  decoded controls.
REQ-013 o_EX_data_Funct / o_EX_data_Opcode  out  6 each  raw fields for ALU control in EX.

Function
REQ-014 IF/ID register (instr, PCNext, valid) SHALL load inputs with valid=1 on each clk edge when Stall=0, and SHALL hold all contents when Stall=1.
REQ-015 Register file SHALL be 32x32, written on clk edge when WbEn=1 and WbAddr!=0; writes to r0 SHALL be discarded; reads of r0 SHALL return 0.
REQ-016 With WB_BYPASS=1, a read whose address equals WbAddr while WbEn=1 and WbAddr!=0 SHALL return WbData in the same cycle.
REQ-017 Outputs to EX and IF SHALL be combinational from the IF/ID register and register file (zero added latency after IF/ID).
REQ-018 Decode: opcode 0 -> R-type (RegWrite, RegDst); 0x08 addi (RegWrite, ALUSrc); 0x23 lw (RegWrite, MemRead, ALUSrc); 0x2B sw (MemWrite, ALUSrc); 0x04 beq; 0x05 bne; 0x02 j; all others -> all controls 0, Valid still 1.
REQ-019 Imm SHALL equal {{16{instr[15]}}, instr[15:0]}.
REQ-020 beq/bne target SHALL be PCNext + (Imm << 2), modulo 2^32; j target SHALL be {PCNext[31:28], instr[25:0], 2'b00}.
REQ-021 PCSrc SHALL be 1 iff valid=1, Stall=0, and (j, or beq with RsData==RtData, or bne with RsData!=RtData), using bypassed operands.
REQ-022 Instruction after a taken branch (delay slot) SHALL NOT be flushed.
REQ-023 When Stall=1 or valid=0, o_EX_ctrl_Valid and all o_EX_ctrl_* SHALL be 0 and PCSrc SHALL be 0; data outputs unconstrained.
REQ-024 A write-back and a stall in the same cycle SHALL both take effect; the held instruction re-reads updated registers next cycle.

Reset
REQ-025 nrst=0 SHALL immediately clear IF/ID valid, set instr to NOP_INSTR, PCNext to 0, and all 32 registers to 0, independent of clk.
REQ-026 During and after reset until first load: PCSrc=0, PCBranch=don't-care-but-stable, all o_EX_ctrl_*=0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight instruction and any same-edge write-back.

Verification
REQ-028 Reset, then WB r1=5, r2=5; load beq r1,r2,+3 with PCNext 0x40020000 -> PCSrc=1, PCBranch=0x4002000C.
REQ-029 WB r3=0x1234 same cycle as decoding add r4,r3,r0 -> RsData=0x1234 (bypass), RegWrite=1, RegDst=1.
REQ-030 WB to r0 with 0xFFFFFFFF, then read r0 -> 0.
REQ-031 Load lw r5,-4(r6) then Stall=1 for 2 cycles -> Valid=0, controls 0 during stall; after release Valid=1, MemRead=1, Imm=0xFFFFFFFC, same instruction presented.
REQ-032 j 0x0100000 with PCNext 0x40020004 -> PCSrc=1, PCBranch=0x40400000; bne with equal operands -> PCSrc=0.
REQ-033 Assert nrst mid-decode of a taken beq -> PCSrc drops to 0 immediately, registers read 0.

Source files
------------

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction decode stage of a 5-stage MIPS-like pipeline.
//
// Holds the IF/ID pipeline register and the 32x32 register file. Everything
// presented to EX and to IF is combinational from the IF/ID register and the
// register file, so decode adds no latency beyond the IF/ID register.
//
// Flow control (single hold signal, no valid/ready pair on this boundary):
//   i_ID_ctrl_Stall=1 freezes the IF/ID register. In the same cycle a bubble
//   is shown to EX (Valid and every decoded control forced to 0) and no
//   redirect is raised. IF is frozen by the same signal outside this block,
//   so no fetched instruction is lost. When Stall drops, the held instruction
//   is presented again with fresh register reads.
//
// The branch delay slot is architectural: the instruction fetched after a
// taken branch or jump is never flushed here.
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int          WB_BYPASS = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic [31:0] i_ID_data_instruction,
    input  logic [31:0] i_ID_data_PCNext,
    input  logic        i_ID_ctrl_Stall,

    input  logic        i_ID_ctrl_WbEn,
    input  logic [4:0]  i_ID_data_WbAddr,
    input  logic [31:0] i_ID_data_WbData,

    output logic        o_IF_ctrl_PCSrc,
    output logic [31:0] o_IF_data_PCBranch,

    output logic [31:0] o_EX_data_RsData,
    output logic [31:0] o_EX_data_RtData,
    output logic [31:0] o_EX_data_Imm,
    output logic [4:0]  o_EX_data_Rs,
    output logic [4:0]  o_EX_data_Rt,
    output logic [4:0]  o_EX_data_Rd,

    output logic        o_EX_ctrl_Valid,
    output logic        o_EX_ctrl_RegWrite,
    output logic        o_EX_ctrl_MemRead,
    output logic        o_EX_ctrl_MemWrite,
    output logic        o_EX_ctrl_ALUSrc,
    output logic        o_EX_ctrl_RegDst,

    output logic [5:0]  o_EX_data_Funct,
    output logic [5:0]  o_EX_data_Opcode
);

    // Opcodes recognised by the decoder; anything else decodes to no controls.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // IF/ID pipeline register
    logic [31:0] r_instr;
    logic [31:0] r_pc_next;
    logic        r_valid;

    // Register file; entry 0 is never written and never read back.
    logic [31:0] r_regs [32];

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_imm;

    // Operand read path
    logic        w_wb_write;
    logic        w_byp_rs;
    logic        w_byp_rt;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;

    // Raw decode, before bubble gating
    logic        w_dec_regwrite;
    logic        w_dec_memread;
    logic        w_dec_memwrite;
    logic        w_dec_alusrc;
    logic        w_dec_regdst;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_j;

    // Branch resolution
    logic        w_active;
    logic        w_operands_eq;
    logic        w_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    // IF/ID register: load on every non-stalled edge, hold while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_instr   <= NOP_INSTR;
            r_pc_next <= 32'h0;
            r_valid   <= 1'b0;
        end else if (!i_ID_ctrl_Stall) begin
            r_instr   <= i_ID_data_instruction;
            r_pc_next <= i_ID_data_PCNext;
            r_valid   <= 1'b1;
        end
    end

    // Write-back port; writes to r0 are dropped. Stall does not block it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (w_wb_write) begin
            r_regs[i_ID_data_WbAddr] <= i_ID_data_WbData;
        end
    end

    assign w_opcode = r_instr[31:26];
    assign w_rs     = r_instr[25:21];
    assign w_rt     = r_instr[20:16];
    assign w_rd     = r_instr[15:11];
    assign w_funct  = r_instr[5:0];
    assign w_imm    = {{16{r_instr[15]}}, r_instr[15:0]};

    assign w_wb_write = i_ID_ctrl_WbEn && (i_ID_data_WbAddr != 5'd0);
    assign w_byp_rs   = (WB_BYPASS != 0) && w_wb_write && (i_ID_data_WbAddr == w_rs);
    assign w_byp_rt   = (WB_BYPASS != 0) && w_wb_write && (i_ID_data_WbAddr == w_rt);

    // Operand read: r0 is hard zero, then same-cycle write-back forwarding.
    always_comb begin
        w_rs_data = r_regs[w_rs];
        w_rt_data = r_regs[w_rt];
        if (w_rs == 5'd0) begin
            w_rs_data = 32'h0;
        end else if (w_byp_rs) begin
            w_rs_data = i_ID_data_WbData;
        end
        if (w_rt == 5'd0) begin
            w_rt_data = 32'h0;
        end else if (w_byp_rt) begin
            w_rt_data = i_ID_data_WbData;
        end
    end

    // Opcode decode into raw control flags.
    always_comb begin
        w_dec_regwrite = 1'b0;
        w_dec_memread  = 1'b0;
        w_dec_memwrite = 1'b0;
        w_dec_alusrc   = 1'b0;
        w_dec_regdst   = 1'b0;
        w_is_beq       = 1'b0;
        w_is_bne       = 1'b0;
        w_is_j         = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_dec_regwrite = 1'b1;
                w_dec_regdst   = 1'b1;
            end
            OP_ADDI: begin
                w_dec_regwrite = 1'b1;
                w_dec_alusrc   = 1'b1;
            end
            OP_LW: begin
                w_dec_regwrite = 1'b1;
                w_dec_memread  = 1'b1;
                w_dec_alusrc   = 1'b1;
            end
            OP_SW: begin
                w_dec_memwrite = 1'b1;
                w_dec_alusrc   = 1'b1;
            end
            OP_BEQ:  w_is_beq = 1'b1;
            OP_BNE:  w_is_bne = 1'b1;
            OP_J:    w_is_j   = 1'b1;
            default: begin
            end
        endcase
    end

    // A held or empty IF/ID register shows a bubble and never redirects.
    assign w_active      = r_valid && !i_ID_ctrl_Stall;
    assign w_operands_eq = (w_rs_data == w_rt_data);
    assign w_taken       = w_is_j || (w_is_beq && w_operands_eq) || (w_is_bne && !w_operands_eq);

    assign w_br_target = r_pc_next + {w_imm[29:0], 2'b00};
    assign w_j_target  = {r_pc_next[31:28], r_instr[25:0], 2'b00};

    assign o_IF_ctrl_PCSrc    = w_active && w_taken;
    assign o_IF_data_PCBranch = w_is_j ? w_j_target : w_br_target;

    assign o_EX_data_RsData = w_rs_data;
    assign o_EX_data_RtData = w_rt_data;
    assign o_EX_data_Imm    = w_imm;
    assign o_EX_data_Rs     = w_rs;
    assign o_EX_data_Rt     = w_rt;
    assign o_EX_data_Rd     = w_rd;
    assign o_EX_data_Funct  = w_funct;
    assign o_EX_data_Opcode = w_opcode;

    assign o_EX_ctrl_Valid    = w_active;
    assign o_EX_ctrl_RegWrite = w_active && w_dec_regwrite;
    assign o_EX_ctrl_MemRead  = w_active && w_dec_memread;
    assign o_EX_ctrl_MemWrite = w_active && w_dec_memwrite;
    assign o_EX_ctrl_ALUSrc   = w_active && w_dec_alusrc;
    assign o_EX_ctrl_RegDst   = w_active && w_dec_regdst;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage.
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// more unit later, well away from either clock edge.
// Control snapshot bit order: {PCSrc, Valid, RegWrite, MemRead, MemWrite,
// ALUSrc, RegDst}.
// ---------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        nrst;
    logic [31:0] i_ID_data_instruction;
    logic [31:0] i_ID_data_PCNext;
    logic        i_ID_ctrl_Stall;
    logic        i_ID_ctrl_WbEn;
    logic [4:0]  i_ID_data_WbAddr;
    logic [31:0] i_ID_data_WbData;
    logic        o_IF_ctrl_PCSrc;
    logic [31:0] o_IF_data_PCBranch;
    logic [31:0] o_EX_data_RsData;
    logic [31:0] o_EX_data_RtData;
    logic [31:0] o_EX_data_Imm;
    logic [4:0]  o_EX_data_Rs;
    logic [4:0]  o_EX_data_Rt;
    logic [4:0]  o_EX_data_Rd;
    logic        o_EX_ctrl_Valid;
    logic        o_EX_ctrl_RegWrite;
    logic        o_EX_ctrl_MemRead;
    logic        o_EX_ctrl_MemWrite;
    logic        o_EX_ctrl_ALUSrc;
    logic        o_EX_ctrl_RegDst;
    logic [5:0]  o_EX_data_Funct;
    logic [5:0]  o_EX_data_Opcode;

    logic [6:0]  obs_ctrl;
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    int          n_compared;
    int          n_mismatched;

    id_stage #(.WB_BYPASS(1), .NOP_INSTR(32'h0000_0000)) dut (
        .clk                   (clk),
        .nrst                  (nrst),
        .i_ID_data_instruction (i_ID_data_instruction),
        .i_ID_data_PCNext      (i_ID_data_PCNext),
        .i_ID_ctrl_Stall       (i_ID_ctrl_Stall),
        .i_ID_ctrl_WbEn        (i_ID_ctrl_WbEn),
        .i_ID_data_WbAddr      (i_ID_data_WbAddr),
        .i_ID_data_WbData      (i_ID_data_WbData),
        .o_IF_ctrl_PCSrc       (o_IF_ctrl_PCSrc),
        .o_IF_data_PCBranch    (o_IF_data_PCBranch),
        .o_EX_data_RsData      (o_EX_data_RsData),
        .o_EX_data_RtData      (o_EX_data_RtData),
        .o_EX_data_Imm         (o_EX_data_Imm),
        .o_EX_data_Rs          (o_EX_data_Rs),
        .o_EX_data_Rt          (o_EX_data_Rt),
        .o_EX_data_Rd          (o_EX_data_Rd),
        .o_EX_ctrl_Valid       (o_EX_ctrl_Valid),
        .o_EX_ctrl_RegWrite    (o_EX_ctrl_RegWrite),
        .o_EX_ctrl_MemRead     (o_EX_ctrl_MemRead),
        .o_EX_ctrl_MemWrite    (o_EX_ctrl_MemWrite),
        .o_EX_ctrl_ALUSrc      (o_EX_ctrl_ALUSrc),
        .o_EX_ctrl_RegDst      (o_EX_ctrl_RegDst),
        .o_EX_data_Funct       (o_EX_data_Funct),
        .o_EX_data_Opcode      (o_EX_data_Opcode)
    );

    assign obs_ctrl = {o_IF_ctrl_PCSrc, o_EX_ctrl_Valid, o_EX_ctrl_RegWrite, o_EX_ctrl_MemRead,
                       o_EX_ctrl_MemWrite, o_EX_ctrl_ALUSrc, o_EX_ctrl_RegDst};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [31:0] instr, input logic [31:0] pc);
        i_ID_data_instruction = instr;
        i_ID_data_PCNext      = pc;
        i_ID_ctrl_Stall       = 1'b0;
        step();
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        i_ID_ctrl_WbEn   = 1'b1;
        i_ID_data_WbAddr = addr;
        i_ID_data_WbData = data;
        step();
        i_ID_ctrl_WbEn   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0;
        i_ID_data_instruction = 32'h0;
        i_ID_data_PCNext      = 32'h0;
        i_ID_ctrl_Stall       = 1'b0;
        i_ID_ctrl_WbEn        = 1'b0;
        i_ID_data_WbAddr      = 5'd0;
        i_ID_data_WbData      = 32'h0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #3;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL reset_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        #9;  // release at t=12, between edges
        nrst = 1'b1;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL post_reset_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
    endtask

    task automatic test_beq_taken();
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd5);
        exp_q.push_back(32'b1100000);
        exp_q.push_back(32'h4002_000C);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd5);
        load_instr(32'h1022_0003, 32'h4002_0000);  // beq r1,r2,+3
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL beq_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_IF_data_PCBranch !== exp) begin
            n_mismatched++;
            $display("FAIL beq_target: got %h expected %h", o_IF_data_PCBranch, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL beq_rs: got %h expected %h", o_EX_data_RsData, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RtData !== exp) begin
            n_mismatched++;
            $display("FAIL beq_rt: got %h expected %h", o_EX_data_RtData, exp);
        end
    endtask

    task automatic test_bypass();
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'b0110001);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h1234);
        load_instr(32'h0060_2020, 32'h0000_0100);  // add r4,r3,r0
        i_ID_ctrl_WbEn   = 1'b1;
        i_ID_data_WbAddr = 5'd3;
        i_ID_data_WbData = 32'h1234;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL bypass_rs: got %h expected %h", o_EX_data_RsData, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL rtype_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if ({27'h0, o_EX_data_Rd} !== exp) begin
            n_mismatched++;
            $display("FAIL rtype_rd: got %0d expected %0d", o_EX_data_Rd, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if ({26'h0, o_EX_data_Funct} !== exp) begin
            n_mismatched++;
            $display("FAIL rtype_funct: got %h expected %h", o_EX_data_Funct, exp);
        end
        step();  // r3 written at this edge, same instruction reloaded
        i_ID_ctrl_WbEn = 1'b0;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL r3_stored: got %h expected %h", o_EX_data_RsData, exp);
        end
    endtask

    task automatic test_r0();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        load_instr(32'h0000_0820, 32'h0000_0200);  // add r1,r0,r0
        i_ID_ctrl_WbEn   = 1'b1;
        i_ID_data_WbAddr = 5'd0;
        i_ID_data_WbData = 32'hFFFF_FFFF;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL r0_no_bypass: got %h expected %h", o_EX_data_RsData, exp);
        end
        step();
        i_ID_ctrl_WbEn = 1'b0;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RtData !== exp) begin
            n_mismatched++;
            $display("FAIL r0_read: got %h expected %h", o_EX_data_RtData, exp);
        end
    endtask

    task automatic test_stall();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'b0111010);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h8CC5_FFFC);
        exp_q.push_back(32'h77);
        load_instr(32'h8CC5_FFFC, 32'h0000_0300);  // lw r5,-4(r6)
        i_ID_ctrl_Stall       = 1'b1;
        i_ID_data_instruction = 32'h2002_0001;      // must not be taken in
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL stall1_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        i_ID_ctrl_WbEn   = 1'b1;                    // write-back during stall
        i_ID_data_WbAddr = 5'd6;
        i_ID_data_WbData = 32'h77;
        step();
        i_ID_ctrl_WbEn = 1'b0;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL stall2_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        step();
        i_ID_ctrl_Stall = 1'b0;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL lw_release_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_Imm !== exp) begin
            n_mismatched++;
            $display("FAIL lw_imm: got %h expected %h", o_EX_data_Imm, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if ({o_EX_data_Opcode, o_EX_data_Rs, o_EX_data_Rt, o_EX_data_Imm[15:0]} !== exp) begin
            n_mismatched++;
            $display("FAIL lw_held_instr: got %h expected %h",
                     {o_EX_data_Opcode, o_EX_data_Rs, o_EX_data_Rt, o_EX_data_Imm[15:0]}, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL stall_wb_reread: got %h expected %h", o_EX_data_RsData, exp);
        end
    endtask

    task automatic test_jump_bne();
        exp_q.push_back(32'b1100000);
        exp_q.push_back(32'h4040_0000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'b0100000);
        load_instr(32'h0810_0000, 32'h4002_0004);  // j 0x0100000
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL j_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_IF_data_PCBranch !== exp) begin
            n_mismatched++;
            $display("FAIL j_target: got %h expected %h", o_IF_data_PCBranch, exp);
        end
        i_ID_ctrl_Stall = 1'b1;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL j_stalled_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        load_instr(32'h1422_0003, 32'h4002_0008);  // bne r1,r2 with r1==r2
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL bne_equal_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
    endtask

    task automatic test_decode();
        logic [31:0] instr_tab [5];
        logic [6:0]  ctrl_tab  [5];
        instr_tab[0] = 32'h2000_0000; ctrl_tab[0] = 7'b0110010;  // addi
        instr_tab[1] = 32'hAC00_0000; ctrl_tab[1] = 7'b0100110;  // sw
        instr_tab[2] = 32'hFC00_0000; ctrl_tab[2] = 7'b0100000;  // unknown
        instr_tab[3] = 32'h8C00_0000; ctrl_tab[3] = 7'b0111010;  // lw
        instr_tab[4] = 32'h0000_0000; ctrl_tab[4] = 7'b0110001;  // R-type
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({25'h0, ctrl_tab[k]});
            load_instr(instr_tab[k], 32'h0000_1000);
            #1;
            exp = exp_q.pop_front();
            n_compared++;
            if (obs_ctrl !== exp[6:0]) begin
                n_mismatched++;
                $display("FAIL decode_%0d: instr %h got %b expected %b", k, instr_tab[k], obs_ctrl, exp[6:0]);
            end
        end
    endtask

    task automatic test_random_branch();
        logic [31:0] v7, v8, pc, sext;
        logic [15:0] imm16;
        logic        is_bne, taken;
        for (int k = 0; k < 10; k++) begin
            v7 = $urandom;
            v8 = ($urandom_range(0, 1) == 1) ? v7 : (v7 ^ (32'h1 << $urandom_range(0, 31)));
            wb(5'd7, v7);
            wb(5'd8, v8);
            is_bne = 1'($urandom_range(0, 1));
            imm16  = 16'($urandom_range(0, 65535));
            pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            pc     = pc ^ {$urandom_range(0, 3), 30'h0};
            sext   = {{16{imm16[15]}}, imm16};
            taken  = is_bne ? (v7 != v8) : (v7 == v8);
            exp_q.push_back({31'h0, taken});
            exp_q.push_back(pc + (sext << 2));
            load_instr({(is_bne ? 6'h05 : 6'h04), 5'd7, 5'd8, imm16}, pc);
            #1;
            exp = exp_q.pop_front();
            n_compared++;
            if (o_IF_ctrl_PCSrc !== exp[0]) begin
                n_mismatched++;
                $display("FAIL rand_br_%0d_pcsrc: bne=%0d rs=%h rt=%h got %b expected %b",
                         k, is_bne, v7, v8, o_IF_ctrl_PCSrc, exp[0]);
            end
            exp = exp_q.pop_front();
            n_compared++;
            if (o_IF_data_PCBranch !== exp) begin
                n_mismatched++;
                $display("FAIL rand_br_%0d_target: got %h expected %h", k, o_IF_data_PCBranch, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(32'b1100000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'b0110001);
        load_instr(32'h1022_0003, 32'h4002_0000);  // beq r1,r2 (5==5)
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL pre_reset_beq: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        i_ID_ctrl_WbEn   = 1'b1;                    // must be discarded
        i_ID_data_WbAddr = 5'd9;
        i_ID_data_WbData = 32'h0000_ABCD;
        nrst = 1'b0;
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL mid_reset_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL mid_reset_rs: got %h expected %h", o_EX_data_RsData, exp);
        end
        step();                                     // edge while in reset
        i_ID_ctrl_WbEn = 1'b0;
        nrst = 1'b1;
        load_instr(32'h0029_5020, 32'h0000_0400);  // add r10,r1,r9
        #1;
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RsData !== exp) begin
            n_mismatched++;
            $display("FAIL r1_cleared: got %h expected %h", o_EX_data_RsData, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (o_EX_data_RtData !== exp) begin
            n_mismatched++;
            $display("FAIL r9_wb_discarded: got %h expected %h", o_EX_data_RtData, exp);
        end
        exp = exp_q.pop_front();
        n_compared++;
        if (obs_ctrl !== exp[6:0]) begin
            n_mismatched++;
            $display("FAIL post_mid_reset_ctrl: got %b expected %b", obs_ctrl, exp[6:0]);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_beq_taken();
        test_bypass();
        test_r0();
        test_stall();
        test_jump_bne();
        test_decode();
        test_random_branch();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d expected entries left over, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
